// File: rtl/sort_n_floats_seq.sv
// Sequential sorter for batches of N floating-point values.
//
// Elements stream in on the up handshake until N are buffered. The buffer is
// then bubble-sorted with one compare/swap per cycle using a single shared
// comparator, and the elements stream out in ascending order on the down
// handshake.
//
// Ports (sort_n_floats_seq):
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   up_valid   in   up_data holds an element
//   up_data    in   unsorted element (FLEN bits)
//   up_ready   out  element accepted this cycle (LOAD state)
//   down_valid out  down_data holds a sorted element (UNLOAD state)
//   down_data  out  sorted element, ascending
//   down_last  out  current down element is the last of the batch
//   down_err   out  batch aborted because a comparison hit a NaN
//   down_ready in   consumer accepts the current down element
//
// Ports (f_less_or_equal):
//   a, b  in   operands
//   res   out  a <= b (IEEE ordering, -0 == +0); 0 when err is set
//   err   out  at least one operand is NaN

// FLEN normally comes from the shared config header; fall back to FP64.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal #(
  parameter int unsigned Flen = 64
) (
  input  logic [Flen-1:0] a,
  input  logic [Flen-1:0] b,
  output logic            res,
  output logic            err
);
  localparam int unsigned ExpW  = (Flen == 32) ? 8 : (Flen == 16) ? 5 : 11;
  localparam int unsigned MantW = Flen - 1 - ExpW;

  logic            sign_a, sign_b;
  logic [Flen-2:0] mag_a, mag_b;
  logic            nan_a, nan_b;

  assign sign_a = a[Flen-1];
  assign sign_b = b[Flen-1];
  assign mag_a  = a[Flen-2:0];
  assign mag_b  = b[Flen-2:0];
  assign nan_a  = (&a[Flen-2 -: ExpW]) && (|a[MantW-1:0]);
  assign nan_b  = (&b[Flen-2 -: ExpW]) && (|b[MantW-1:0]);

  always_comb begin
    err = nan_a | nan_b;
    res = 1'b0;
    if (!err) begin
      if (mag_a == '0 && mag_b == '0) begin
        res = 1'b1;                   // +0 and -0 compare equal
      end else if (sign_a != sign_b) begin
        res = sign_a;                 // negative is smaller
      end else if (!sign_a) begin
        res = (mag_a <= mag_b);
      end else begin
        res = (mag_a >= mag_b);       // larger magnitude is smaller when negative
      end
    end
  end
endmodule

module sort_n_floats_seq #(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [`FLEN-1:0]  up_data,
  output logic              up_ready,
  output logic              down_valid,
  output logic [`FLEN-1:0]  down_data,
  output logic              down_last,
  output logic              down_err,
  input  logic              down_ready
);
  localparam int unsigned Flen = `FLEN;
  localparam int unsigned IdxW = $clog2(N);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {StLoad, StSort, StUnload} state_e;

  localparam idx_t LastIdx = idx_t'(N - 1);
  localparam idx_t LastCmp = idx_t'(N - 2);

  state_e          state_q, state_d;
  idx_t            wr_idx_q, wr_idx_d;
  idx_t            rd_idx_q, rd_idx_d;
  idx_t            cmp_idx_q, cmp_idx_d;
  idx_t            pass_q, pass_d;
  logic            swapped_q, swapped_d;
  logic            err_flag_q, err_flag_d;
  logic [Flen-1:0] buf_q [N];

  idx_t            cmp_nxt;
  logic [Flen-1:0] cmp_a, cmp_b;
  logic            cmp_res, cmp_err;
  logic            load_fire, swap;

  assign cmp_nxt = cmp_idx_q + idx_t'(1);
  assign cmp_a   = buf_q[cmp_idx_q];
  assign cmp_b   = buf_q[cmp_nxt];

  f_less_or_equal #(
    .Flen (Flen)
  ) u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  assign load_fire = (state_q == StLoad) && up_valid;
  assign swap      = (state_q == StSort) && !cmp_res && !cmp_err;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    cmp_idx_d  = cmp_idx_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    err_flag_d = err_flag_q;

    unique case (state_q)
      StLoad: begin
        if (up_valid) begin
          if (wr_idx_q == LastIdx) begin
            state_d    = StSort;
            wr_idx_d   = '0;
            cmp_idx_d  = '0;
            pass_d     = '0;
            swapped_d  = 1'b0;
            err_flag_d = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + idx_t'(1);
          end
        end
      end
      StSort: begin
        if (cmp_err) begin
          err_flag_d = 1'b1;
          state_d    = StUnload;
          rd_idx_d   = '0;
        end else begin
          if (swap) begin
            swapped_d = 1'b1;
          end
          if (cmp_idx_q == LastCmp) begin
            // A pass with no swaps means the buffer is already ordered.
            if (!(swapped_q || swap) || pass_q == LastCmp) begin
              state_d  = StUnload;
              rd_idx_d = '0;
            end else begin
              pass_d    = pass_q + idx_t'(1);
              swapped_d = 1'b0;
              cmp_idx_d = '0;
            end
          end else begin
            cmp_idx_d = cmp_nxt;
          end
        end
      end
      StUnload: begin
        if (down_ready) begin
          if (rd_idx_q == LastIdx) begin
            state_d  = StLoad;
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + idx_t'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      cmp_idx_q  <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      cmp_idx_q  <= cmp_idx_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Buffer carries no reset; its contents are only visible in UNLOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        buf_q[wr_idx_q] <= up_data;
      end
      if (swap) begin
        buf_q[cmp_idx_q] <= cmp_b;
        buf_q[cmp_nxt]   <= cmp_a;
      end
    end
  end

  always_comb begin
    up_ready   = 1'b0;
    down_valid = 1'b0;
    down_data  = '0;
    down_last  = 1'b0;
    down_err   = 1'b0;
    if (state_q == StLoad) begin
      up_ready = 1'b1;
    end
    if (state_q == StUnload) begin
      down_valid = 1'b1;
      down_data  = buf_q[rd_idx_q];
      down_last  = (rd_idx_q == LastIdx);
      down_err   = err_flag_q;
    end
  end
endmodule

// File: doc/sort_n_floats_seq.md
SORT_N_FLOATS_SEQ -- requirements
Module: sort_n_floats_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning the number of FLEN-bit floats per sort batch; legal range 2..64.
REQ-002 SHALL take FLEN from the shared config header; FLEN is not a module parameter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port up_valid, input, 1 bit: up_data holds an element.
REQ-006 SHALL have port up_data, input, FLEN bits: unsorted element.
REQ-007 SHALL have port up_ready, output, 1 bit: block accepts an element this cycle.
REQ-008 SHALL have port down_valid, output, 1 bit: down_data holds a sorted element.
REQ-009 SHALL have port down_data, output, FLEN bits: sorted element, ascending order.
REQ-010 SHALL have port down_last, output, 1 bit: current down element is index N-1.
REQ-011 SHALL have port down_err, output, 1 bit: batch aborted on a comparator error; constant for the whole unload.
REQ-012 SHALL have port down_ready, input, 1 bit: consumer accepts the current down element.

Function
REQ-013 SHALL contain exactly one f_less_or_equal instance; all ordering decisions SHALL come from it.
REQ-014 SHALL store N elements in an internal buffer buf[0..N-1].
REQ-015 SHALL implement the states LOAD, SORT and UNLOAD only.
REQ-016 LOAD: up_ready=1 and down_valid=0; each up_valid&&up_ready writes up_data to buf[wr_idx] and increments wr_idx.
REQ-017 LOAD: the transfer with wr_idx=N-1 SHALL move the state to SORT on the next cycle, with cmp_idx=0, pass=0, swapped=0 and err_flag=0.
REQ-018 SORT: up_ready=0 and down_valid=0; each cycle compares a=buf[cmp_idx] and b=buf[cmp_idx+1].
REQ-019 SORT: when res=0 and err=0, buf[cmp_idx] and buf[cmp_idx+1] SHALL swap and swapped SHALL be set to 1.
REQ-020 SORT: when res=1, the buffer SHALL be unchanged, so equal elements keep their input order (stable sort).
REQ-021 SORT: when err=1, the buffer SHALL be unchanged, err_flag SHALL be set and the state SHALL move to UNLOAD on the next cycle.
REQ-022 SORT: cmp_idx runs 0..N-2, one comparison per cycle; one pass takes N-1 cycles.
REQ-023 End of pass: if swapped=0 or pass=N-2, go to UNLOAD; otherwise increment pass, clear swapped and set cmp_idx=0.
REQ-024 Sort latency SHALL be between N-1 cycles (input already sorted) and (N-1)^2 cycles.
REQ-025 UNLOAD: down_valid=1, down_data=buf[rd_idx], down_last=(rd_idx==N-1), down_err=err_flag.
REQ-026 UNLOAD: rd_idx advances only on down_valid&&down_ready; down_data SHALL hold stable while down_ready=0.
REQ-027 UNLOAD: the transfer with down_last=1 SHALL return the state to LOAD with wr_idx=0; no idle cycle is required before the next up transfer.
REQ-028 An up_valid outside LOAD SHALL be ignored; down_ready outside UNLOAD SHALL be ignored.
REQ-029 The ordering of NaN elements after an abort is unspecified; the count of elements output SHALL still be exactly N.

Reset
REQ-030 While rst=1 at a clock edge, the state SHALL become LOAD and wr_idx, rd_idx, cmp_idx, pass, swapped and err_flag SHALL become 0.
REQ-031 After reset: up_ready=1, down_valid=0, down_last=0, down_err=0; buffer contents are don't-care and never appear on down_data.
REQ-032 Reset asserted in any state (mid-load, mid-sort or mid-unload) SHALL discard the batch; no further elements of it are output.

Verification (N=4, FP64)
REQ-033 Load 3.0, 1.0, 2.0, -0.5 -> output -0.5, 1.0, 2.0, 3.0; down_last only on 3.0; down_err=0.
REQ-034 Load 1.0, 2.0, 3.0, 4.0 -> exactly 3 SORT cycles between the last up transfer and the first down_valid; output unchanged.
REQ-035 Load 4.0, 3.0, 2.0, 1.0 -> 9 SORT cycles; output 1.0, 2.0, 3.0, 4.0.
REQ-036 Load 2.0, NaN, 1.0, 0.0 -> down_err=1 on all 4 outputs; exactly 4 transfers; the block then returns to LOAD.
REQ-037 Toggle down_ready randomly during unload -> down_data stable while down_ready=0, and no element is lost or duplicated; up_valid held at 1 is ignored.
REQ-038 Assert rst after the 2nd down transfer -> down_valid=0 next cycle and up_ready=1; a new batch 5.0, 5.0, -1.0, 0.5 sorts to -1.0, 0.5, 5.0, 5.0.
